// File: rtl/compmag_bist.sv
// compmag_bist: self-test engine for a W-bit magnitude comparator.
// Drives pseudo-random operand pairs (two 16-bit Fibonacci LFSRs) onto a/b,
// samples the comparator flags after SETTLE extra cycles, checks them against
// an internal unsigned compare and counts mismatches (saturating).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             run request, accepted only in IDLE or DONE
//   a, b              registered operands to the comparator
//   aeqb, agtb, altb  comparator flags under test
//   busy              high while a run is in progress (SETTLE/CHECK)
//   done, pass        run finished / finished with zero mismatches
//   erros             saturating mismatch count
//   vec_cnt           vectors checked so far
//
// Optional build macro COMPMAG_BIST_FIRSTFAIL_EN adds fail_a, fail_b,
// fail_idx and fail_seen, which capture the first mismatching vector of a run.
module compmag_bist #(
  parameter int unsigned W      = 7,
  parameter int unsigned NVEC   = 500,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned ERRW   = 16,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [W-1:0]    a,
  output logic [W-1:0]    b,
  input  logic            aeqb,
  input  logic            agtb,
  input  logic            altb,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] erros,
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
  output logic [W-1:0]    fail_a,
  output logic [W-1:0]    fail_b,
  output logic [15:0]     fail_idx,
  output logic            fail_seen,
`endif
  output logic [15:0]     vec_cnt
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 4;
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(NVEC - 1);
  localparam logic [WAIT_W-1:0] SETTLE_INIT = WAIT_W'(SETTLE);
  localparam logic [ERRW-1:0]   ERR_MAX     = {ERRW{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  // Fibonacci step, taps x^16+x^14+x^13+x^11+1
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [W-1:0]        a_d, b_d;
  logic [ERRW-1:0]     erros_d;
  logic [CNT_W-1:0]    vec_cnt_d;
  logic                busy_d, done_d, pass_d;
  logic [2:0]          golden;
  logic                mismatch;
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
  logic [W-1:0]        fail_a_d, fail_b_d;
  logic [CNT_W-1:0]    fail_idx_d;
  logic                fail_seen_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    wait_d    = wait_q;
    a_d       = a;
    b_d       = b;
    erros_d   = erros;
    vec_cnt_d = vec_cnt;
    golden    = {a == b, a > b, a < b};
    mismatch  = 1'b0;
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    fail_a_d    = fail_a;
    fail_b_d    = fail_b;
    fail_idx_d  = fail_idx;
    fail_seen_d = fail_seen;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_a_d  = SEED_A;
          lfsr_b_d  = SEED_B;
          a_d       = SEED_A[W-1:0];
          b_d       = SEED_B[W-1:0];
          erros_d   = '0;
          vec_cnt_d = '0;
          wait_d    = SETTLE_INIT;
          state_d   = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
          fail_a_d    = '0;
          fail_b_d    = '0;
          fail_idx_d  = '0;
          fail_seen_d = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        mismatch = ({aeqb, agtb, altb} != golden);
        if (mismatch && (erros != ERR_MAX)) erros_d = erros + ERRW'(1);
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
        if (mismatch && !fail_seen) begin
          fail_a_d    = a;
          fail_b_d    = b;
          fail_idx_d  = vec_cnt;
          fail_seen_d = 1'b1;
        end
`endif
        vec_cnt_d = vec_cnt + CNT_W'(1);
        if (vec_cnt == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          lfsr_a_d = lfsr_step(lfsr_a_q);
          lfsr_b_d = lfsr_step(lfsr_b_q);
          a_d      = lfsr_a_d[W-1:0];
          b_d      = lfsr_b_d[W-1:0];
          wait_d   = SETTLE_INIT;
          state_d  = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (erros_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      wait_q   <= '0;
      a        <= '0;
      b        <= '0;
      erros    <= '0;
      vec_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
      fail_a    <= '0;
      fail_b    <= '0;
      fail_idx  <= '0;
      fail_seen <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      wait_q   <= wait_d;
      a        <= a_d;
      b        <= b_d;
      erros    <= erros_d;
      vec_cnt  <= vec_cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
      fail_a    <= fail_a_d;
      fail_b    <= fail_b_d;
      fail_idx  <= fail_idx_d;
      fail_seen <= fail_seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_compmag_bist.sv
// Directed bench for compmag_bist: golden loopback, stuck comparator,
// slow comparator with SETTLE=3, error saturation, reset and start handling.
module tb_compmag_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_g, start_g, rst_o, start_o;

  // Golden loopback instance
  logic [6:0]  g_a, g_b;
  logic        g_busy, g_done, g_pass;
  logic [15:0] g_err, g_vec;
  logic        g_eq, g_gt, g_lt;
  assign g_eq = (g_a == g_b);
  assign g_gt = (g_a > g_b);
  assign g_lt = (g_a < g_b);

  // Stuck comparator instance (always reports equal)
  logic [6:0]  k_a, k_b;
  logic        k_busy, k_done, k_pass;
  logic [15:0] k_err, k_vec;

  // Slow comparator: flags are inverted except in the cycle before the sampling edge
  logic [6:0]  s_a, s_b;
  logic        s_busy, s_done, s_pass;
  logic [15:0] s_err, s_vec;
  int          st_cyc;
  logic [2:0]  s_flags;
  always @(posedge clk) st_cyc <= start_o ? 0 : st_cyc + 1;
  assign s_flags = ((st_cyc % 4) == 3) ? {s_a == s_b, s_a > s_b, s_a < s_b}
                                       : ~{s_a == s_b, s_a > s_b, s_a < s_b};

  // Saturation instance with inverted flags
  logic [6:0]  t_a, t_b;
  logic        t_busy, t_done, t_pass;
  logic [1:0]  t_err;
  logic [15:0] t_vec;
  logic [2:0]  t_flags;
  assign t_flags = ~{t_a == t_b, t_a > t_b, t_a < t_b};

`ifdef COMPMAG_BIST_FIRSTFAIL_EN
  logic [6:0] g_fa, g_fb, k_fa, k_fb, s_fa, s_fb, t_fa, t_fb;
  logic [15:0] g_fi, k_fi, s_fi, t_fi;
  logic g_fs, k_fs, s_fs, t_fs;
`endif

  compmag_bist u_gold (
    .clk(clk), .rst(rst_g), .start(start_g), .a(g_a), .b(g_b),
    .aeqb(g_eq), .agtb(g_gt), .altb(g_lt), .busy(g_busy), .done(g_done),
    .pass(g_pass), .erros(g_err),
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    .fail_a(g_fa), .fail_b(g_fb), .fail_idx(g_fi), .fail_seen(g_fs),
`endif
    .vec_cnt(g_vec));

  compmag_bist u_stuck (
    .clk(clk), .rst(rst_o), .start(start_o), .a(k_a), .b(k_b),
    .aeqb(1'b1), .agtb(1'b0), .altb(1'b0), .busy(k_busy), .done(k_done),
    .pass(k_pass), .erros(k_err),
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    .fail_a(k_fa), .fail_b(k_fb), .fail_idx(k_fi), .fail_seen(k_fs),
`endif
    .vec_cnt(k_vec));

  compmag_bist #(.NVEC(4), .SETTLE(3)) u_settle (
    .clk(clk), .rst(rst_o), .start(start_o), .a(s_a), .b(s_b),
    .aeqb(s_flags[2]), .agtb(s_flags[1]), .altb(s_flags[0]), .busy(s_busy),
    .done(s_done), .pass(s_pass), .erros(s_err),
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    .fail_a(s_fa), .fail_b(s_fb), .fail_idx(s_fi), .fail_seen(s_fs),
`endif
    .vec_cnt(s_vec));

  compmag_bist #(.ERRW(2), .NVEC(10)) u_sat (
    .clk(clk), .rst(rst_o), .start(start_o), .a(t_a), .b(t_b),
    .aeqb(t_flags[2]), .agtb(t_flags[1]), .altb(t_flags[0]), .busy(t_busy),
    .done(t_done), .pass(t_pass), .erros(t_err),
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    .fail_a(t_fa), .fail_b(t_fb), .fail_idx(t_fi), .fail_seen(t_fs),
`endif
    .vec_cnt(t_vec));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  logic [15:0] la, lb, la1, lb1;
  int exp_uneq;
  int cyc;
  int vec_at;

  initial begin
    // Bench model: expected mismatch count for the stuck comparator
    exp_uneq = 0;
    la = 16'hACE1;
    lb = 16'h1D2C;
    for (int i = 0; i < 500; i++) begin
      if (la[6:0] != lb[6:0]) exp_uneq++;
      la = step16(la);
      lb = step16(lb);
    end
    la1 = step16(16'hACE1);
    lb1 = step16(16'h1D2C);

    rst_g = 1'b1; rst_o = 1'b1; start_g = 1'b0; start_o = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a", g_a, 0);
    chk("rst_b", g_b, 0);
    chk("rst_busy", g_busy, 0);
    chk("rst_done", g_done, 0);
    chk("rst_pass", g_pass, 0);
    chk("rst_err", g_err, 0);
    chk("rst_vec", g_vec, 0);
    rst_g = 1'b0; rst_o = 1'b0;
    @(negedge clk);

    // Start the settle, saturation and stuck instances together
    start_o = 1'b1;
    @(negedge clk);
    start_o = 1'b0;
    chk("stuck_first_a", k_a, 7'h61);
    chk("stuck_first_b", k_b, 7'h2C);
    cyc = 0;
    while (s_busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("settle_busy_cycles", cyc, 16);
    chk("settle_done", s_done, 1);
    chk("settle_err", s_err, 0);
    chk("settle_vec", s_vec, 4);
    chk("settle_pass", s_pass, 1);
    chk("sat_done", t_done, 1);
    chk("sat_err", t_err, 3);
    chk("sat_pass", t_pass, 0);
    chk("sat_vec", t_vec, 10);

    cyc = 0;
    while (!k_done && cyc < 600) begin
      cyc++;
      @(negedge clk);
    end
    chk("stuck_done", k_done, 1);
    chk("stuck_err", k_err, exp_uneq);
    chk("stuck_pass", k_pass, 0);
    chk("stuck_vec", k_vec, 500);
`ifdef COMPMAG_BIST_FIRSTFAIL_EN
    chk("stuck_fail_seen", k_fs, 1);
    chk("stuck_fail_idx", k_fi, 0);
    chk("stuck_fail_a", k_fa, 7'h61);
    chk("stuck_fail_b", k_fb, 7'h2C);
`endif

    // Restart from DONE clears counters and re-runs
    start_o = 1'b1;
    @(negedge clk);
    start_o = 1'b0;
    chk("restart_err", t_err, 0);
    chk("restart_vec", t_vec, 0);
    chk("restart_busy", t_busy, 1);
    chk("restart_done", t_done, 0);
    repeat (12) @(negedge clk);
    chk("restart_sat_err", t_err, 3);
    chk("restart_sat_done", t_done, 1);

    // Golden loopback run, with a start pulse during CHECK
    start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    chk("gold_first_a", g_a, 7'h61);
    chk("gold_first_b", g_b, 7'h2C);
    chk("gold_first_agtb", g_gt, 1);
    chk("gold_busy", g_busy, 1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("gold_second_a", g_a, la1[6:0]);
        chk("gold_second_b", g_b, lb1[6:0]);
      end
      if (cyc == 50) start_g = 1'b1;
      if (cyc == 51) begin
        start_g = 1'b0;
        chk("start_while_busy_vec", g_vec, 51);
      end
    end while (!g_done && cyc < 1000);
    chk("gold_run_cycles", cyc, 500);
    chk("gold_vec", g_vec, 500);
    chk("gold_err", g_err, 0);
    chk("gold_pass", g_pass, 1);
    chk("gold_busy_end", g_busy, 0);

    // Reset mid-run at vector 100
    start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    cyc = 0;
    while (g_vec != 16'd100 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    vec_at = g_vec;
    chk("reach_vec100", vec_at, 100);
    rst_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    chk("midrst_busy", g_busy, 0);
    chk("midrst_a", g_a, 0);
    chk("midrst_b", g_b, 0);
    chk("midrst_err", g_err, 0);
    chk("midrst_done", g_done, 0);
    chk("midrst_vec", g_vec, 0);
    start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    chk("replay_a", g_a, 7'h61);
    chk("replay_b", g_b, 7'h2C);
    @(negedge clk);
    chk("replay_second_a", g_a, la1[6:0]);
    chk("replay_second_b", g_b, lb1[6:0]);

    // Simultaneous reset and start: reset wins
    repeat (5) @(negedge clk);
    rst_g = 1'b1;
    start_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    start_g = 1'b0;
    chk("rst_start_busy", g_busy, 0);
    chk("rst_start_a", g_a, 0);
    chk("rst_start_vec", g_vec, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
